ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Sits beside keyboard_adapter on the same PS2_CLK/PS2_DAT pins. Drives the lines open-drain through output-enable pins.
- Runs the inhibit/request-to-send sequence, shifts out 8 data bits plus odd parity and stop on device-generated clocks, then checks the device ACK.
- Asserts busy so the receiver ignores line activity during a transmission.

Parameters:
- INHIBIT_CYCLES, 6000, clk cycles the host holds PS2 clock low (120 us at 50 MHz).
- START_TIMEOUT, 750000, max cycles from clock release to the first device falling edge (15 ms).
- FRAME_TIMEOUT, 100000, max cycles from the first falling edge to the ACK edge (2 ms).

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- tx_data  in  8  command byte
- tx_valid  in  1  request; byte accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- ps2_clk_i  in  1  raw PS2_CLK pin level (asynchronous)
- ps2_dat_i  in  1  raw PS2_DAT pin level (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release (Z)
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release (Z)
- busy  out  1  high from byte accept until return to IDLE
- done  out  1  one-cycle pulse, frame ACKed by device
- err  out  1  one-cycle pulse, timeout or missing ACK

Behaviour:
- Reset (async, resetn=0): state IDLE. tx_ready=1; busy=done=err=0; ps2_clk_oe=ps2_dat_oe=0, both lines released immediately even mid-frame. All counters cleared.
- Input conditioning: ps2_clk_i and ps2_dat_i each pass through a 2-FF synchronizer. fall = sync_clk_prev & ~sync_clk. Events are seen 2-3 cycles after the pin changes.
- Shift register: on accept, latch {1'b1 stop, ~^tx_data odd parity, tx_data} as a 10-bit shift register, LSB first. Latching happens in the same cycle as accept; later tx_data changes are ignored.
- IDLE: tx_ready=1, no line driven. On accept go to INHIBIT; busy=1 from the next cycle.
- INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES cycles, then REQ.
- REQ: clk_oe=1, dat_oe=1 for exactly 1 cycle (start bit 0), then RUN.
- RUN entry: clk_oe=0; dat_oe stays 1; START_TIMEOUT counter runs.
- RUN, first fall: START_TIMEOUT counter stops and the FRAME_TIMEOUT counter starts.
- RUN, each fall: set dat_oe = ~sreg[0], shift right, increment bit_cnt.
  - Falls 1-8 present d0..d7; fall 9 presents parity; fall 10 presents stop (dat_oe=0, line released).
- RUN, fall 11 (bit_cnt==10): sample sync_dat. 0 → ACK_WAIT. 1 → FAIL.
- ACK_WAIT: wait until sync_clk==1 and sync_dat==1 (device released), then DONE. FRAME_TIMEOUT still applies.
- DONE: done=1 for one cycle, then IDLE.
- FAIL: err=1 for one cycle; both oe=0; then IDLE.
- Timeout in RUN or ACK_WAIT → FAIL. This covers start-timer or frame-timer expiry, e.g. keyboard absent or clock stuck.
- tx_valid asserted outside IDLE is ignored (tx_ready=0); no queuing.
- Falls seen in IDLE, INHIBIT or REQ are ignored; they are not counted.
- Only one frame is in flight at a time. Device responses (0xFA, etc.) are received by keyboard_adapter, not this block.

Decomposition:
- Shared include ps2_defs.vh: state encodings (IDLE, INHIBIT, REQ, RUN, ACK_WAIT, DONE, FAIL); PS/2 command constants (0xED, 0xF4, 0xFF, 0xFA ack); default timing counts at 50 MHz.
- Sub-module ps2_sync_edge: 2-FF synchronizer plus falling-edge detector for clk and data. Reused by keyboard_adapter.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing.
  - Clock held low ≥6000 cycles.
  - Device samples bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once; busy falls.
- Send 0xF4 (five 1s) → parity bit sampled 0. Send 0x00 → parity 1. done pulses each time.
- Device model never clocks → err pulses START_TIMEOUT cycles after clock release; both oe=0; tx_ready=1.
- Device holds data high on the 11th clock (no ACK) → err pulse, no done pulse. The next 0xFF request completes normally.
- Device model stops clocking after bit 4 → err pulses FRAME_TIMEOUT cycles after the first falling edge.
- Deassert resetn mid-RUN → ps2_clk_oe and ps2_dat_oe drop the same cycle (async). After release: IDLE, tx_ready=1, no done/err pulse.
- Pulse tx_valid while busy with a different byte → ignored. The frame on the wire carries only the first byte.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// rtl/ps2_host_tx_pkg.sv - shared states, PS/2 command codes and default timing for the host transmitter
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_RUN,
    ST_ACK_WAIT,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Default counts assume a 50 MHz system clock.
  localparam int DEF_INHIBIT_CYCLES = 6000;
  localparam int DEF_START_TIMEOUT  = 750000;
  localparam int DEF_FRAME_TIMEOUT  = 100000;

  // Wire order is LSB first: d0..d7, odd parity, stop.
  function automatic logic [9:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync_edge.sv
// rtl/ps2_host_tx_sync_edge.sv - 2-FF synchronizers for PS/2 clock and data plus clock falling-edge detect
module ps2_host_tx_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic sync_clk,
  output logic sync_dat,
  output logic clk_fall
);

  logic clk_meta;
  logic dat_meta;
  logic clk_prev;

  // Idle bus level is high, so reset to 1 to avoid a spurious fall after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_meta <= 1'b1;
      sync_clk <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      sync_dat <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_i;
      sync_clk <= clk_meta;
      clk_prev <= sync_clk;
      dat_meta <= ps2_dat_i;
      sync_dat <= dat_meta;
    end
  end

  assign clk_fall = clk_prev & ~sync_clk;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with inhibit/RTS, device-clocked shift-out and ACK check
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int FRAME_TIMEOUT  = DEF_FRAME_TIMEOUT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT, FRAME_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [9:0]       sreg;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic             drive_q;
  logic             sync_clk, sync_dat, clk_fall;
  logic             accept, shift, cnt_clr, cnt_set1, started;

  ps2_host_tx_sync_edge u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .sync_clk  (sync_clk),
    .sync_dat  (sync_dat),
    .clk_fall  (clk_fall)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // The first device fall switches cnt from the start timer to the frame timer.
  assign started = (bit_cnt != 4'd0);

  always_comb begin
    state_nxt  = state;
    tx_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    accept     = 1'b0;
    shift      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_set1   = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) begin
          accept    = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt == INH_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
        cnt_clr    = 1'b1;
        state_nxt  = ST_RUN;
      end
      ST_RUN: begin
        ps2_dat_oe = drive_q;
        if (started && cnt == FRAME_LAST) begin
          state_nxt = ST_FAIL;
        end else if (clk_fall) begin
          cnt_set1 = !started;
          if (bit_cnt == 4'd10) state_nxt = sync_dat ? ST_FAIL : ST_ACK_WAIT;
          else                  shift = 1'b1;
        end else if (!started && cnt == START_LAST) begin
          state_nxt = ST_FAIL;
        end
      end
      ST_ACK_WAIT: begin
        if (cnt == FRAME_LAST)          state_nxt = ST_FAIL;
        else if (sync_clk && sync_dat)  state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_FAIL: begin
        err       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // drive_q starts at 1 so the start bit stays on the line until the first fall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sreg    <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      drive_q <= 1'b0;
    end else begin
      if (accept) begin
        sreg    <= build_frame(tx_data);
        bit_cnt <= '0;
        drive_q <= 1'b1;
      end else if (shift) begin
        drive_q <= ~sreg[0];
        sreg    <= {1'b0, sreg[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (cnt_clr)                cnt <= '0;
      else if (cnt_set1)          cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (state != ST_IDLE)  cnt <= cnt + 1'b1;
    end
  end

endmodule
